// File: rtl/versatile_interface_adapter.sv
// versatile_interface_adapter: NUM_PORTS 8-bit bidirectional ports with per-bit
// direction, optional edge-latched inputs, control-line flags, and a 16-bit
// interval timer (one-shot / continuous), with an active-low IRQ to the CPU.
module versatile_interface_adapter #(
    parameter int NUM_PORTS   = 2,
    parameter int TIMER_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             data_in,
    output logic [7:0]             data_out,
    input  logic [3:0]             register_select,
    input  logic                   chip_en,
    input  logic                   readb_write,
    input  logic [8*NUM_PORTS-1:0] port_in,
    output logic [8*NUM_PORTS-1:0] port_out,
    output logic [8*NUM_PORTS-1:0] port_oe,
    input  logic [NUM_PORTS-1:0]   ctl_in,
    output logic                   irq_n
);

    // Flag/enable bits that physically exist: one per port plus the timer flag.
    localparam logic [6:0] IFR_MASK = 7'h40 | 7'((1 << NUM_PORTS) - 1);
    localparam logic [7:0] ACR_MASK = 8'((1 << (NUM_PORTS + 1)) - 1);
    localparam logic [7:0] PCR_MASK = 8'((1 << NUM_PORTS) - 1);

    logic [NUM_PORTS-1:0][7:0] or_q, or_d;
    logic [NUM_PORTS-1:0][7:0] ddr_q, ddr_d;
    logic [NUM_PORTS-1:0][7:0] irl_q, irl_d;
    logic [NUM_PORTS-1:0][7:0] pin;
    logic [NUM_PORTS-1:0][7:0] ir_val;
    logic [NUM_PORTS-1:0]      ctl_q, ctl_d, ctl_edge;
    logic [7:0]                acr_q, acr_d;
    logic [7:0]                pcr_q, pcr_d;
    logic [7:0]                data_out_q, data_out_d;
    logic [7:0]                rd_val;
    logic [6:0]                ifr_q, ifr_d;
    logic [6:0]                ier_q, ier_d;
    logic [6:0]                ifr_set, ifr_clr;
    logic [TIMER_WIDTH-1:0]    t1c_q, t1c_d;
    logic [TIMER_WIDTH-1:0]    t1l_q, t1l_d;
    logic                      armed_q, armed_d;
    logic                      t1_load;
    logic                      wr_en, rd_en;
    logic                      irq_flag;

    assign pin      = port_in;
    assign ctl_d    = ctl_in;
    assign wr_en    = chip_en & ~readb_write;
    assign rd_en    = chip_en & readb_write;
    assign irq_flag = |(ifr_q & ier_q);
    assign irq_n    = ~irq_flag;
    assign port_out = or_q;
    assign port_oe  = ddr_q;
    assign data_out = data_out_q;

    // Per-port active-edge detect and the value an IR read would return
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            ctl_edge[p] = pcr_q[p] ? (ctl_in[p] & ~ctl_q[p]) : (~ctl_in[p] & ctl_q[p]);
            ir_val[p]   = (ddr_q[p] & or_q[p]) |
                          (~ddr_q[p] & (acr_q[p+1] ? irl_q[p] : pin[p]));
        end
    end

    // Read mux; unimplemented port addresses fall through to 0x00
    always_comb begin
        rd_val = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (register_select == 4'(p))     rd_val = ir_val[p];
            if (register_select == 4'(p + 4)) rd_val = ddr_q[p];
        end
        case (register_select)
            4'h8:    rd_val = t1c_q[7:0];
            4'h9:    rd_val = t1c_q[TIMER_WIDTH-1:8];
            4'hA:    rd_val = t1l_q[7:0];
            4'hB:    rd_val = t1l_q[TIMER_WIDTH-1:8];
            4'hC:    rd_val = acr_q;
            4'hD:    rd_val = pcr_q;
            4'hE:    rd_val = {irq_flag, ifr_q};
            4'hF:    rd_val = {1'b1, ier_q};
            default: ;
        endcase
    end

    // Next-state: register writes, read side effects, edge latching, timer
    always_comb begin
        or_d       = or_q;
        ddr_d      = ddr_q;
        irl_d      = irl_q;
        acr_d      = acr_q;
        pcr_d      = pcr_q;
        ier_d      = ier_q;
        t1c_d      = t1c_q;
        t1l_d      = t1l_q;
        armed_d    = armed_q;
        data_out_d = data_out_q;
        ifr_set    = '0;
        ifr_clr    = '0;
        t1_load    = 1'b0;

        for (int p = 0; p < NUM_PORTS; p++) begin
            if (ctl_edge[p]) begin
                ifr_set[p] = 1'b1;
                if (acr_q[p+1]) irl_d[p] = pin[p];
            end
        end

        if (wr_en) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (register_select == 4'(p))     or_d[p]  = data_in;
                if (register_select == 4'(p + 4)) ddr_d[p] = data_in;
            end
            case (register_select)
                4'h8, 4'hA: t1l_d[7:0] = data_in;
                4'h9: begin
                    t1l_d[TIMER_WIDTH-1:8] = data_in;
                    t1_load                = 1'b1;
                end
                4'hB:    t1l_d[TIMER_WIDTH-1:8] = data_in;
                4'hC:    acr_d = data_in & ACR_MASK;
                4'hD:    pcr_d = data_in & PCR_MASK;
                4'hE:    ifr_clr = data_in[6:0];
                4'hF:    ier_d = data_in[7] ? (ier_q | (data_in[6:0] & IFR_MASK))
                                            : (ier_q & ~data_in[6:0]);
                default: ;
            endcase
        end

        if (rd_en) begin
            data_out_d = rd_val;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (register_select == 4'(p)) ifr_clr[p] = 1'b1;
            end
            if (register_select == 4'h8) ifr_clr[6] = 1'b1;
        end

        // A load edge does not count; zero is held for one edge before the
        // flag/reload, so latch N flags N+1 edges after the load.
        if (t1_load) begin
            t1c_d      = {data_in, t1l_q[7:0]};
            armed_d    = 1'b1;
            ifr_clr[6] = 1'b1;
        end else if (t1c_q != '0) begin
            t1c_d = t1c_q - 1'b1;
        end else begin
            if (armed_q) ifr_set[6] = 1'b1;
            if (acr_q[0]) begin
                t1c_d = t1l_q;
            end else begin
                t1c_d   = '1;
                armed_d = 1'b0;
            end
        end
    end

    // Set beats clear when both hit the same flag in one cycle
    assign ifr_d = ((ifr_q & ~ifr_clr) | ifr_set) & IFR_MASK;

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            or_q       <= '0;
            ddr_q      <= '0;
            irl_q      <= '0;
            ctl_q      <= '0;
            acr_q      <= '0;
            pcr_q      <= '0;
            ifr_q      <= '0;
            ier_q      <= '0;
            t1c_q      <= '0;
            t1l_q      <= '0;
            armed_q    <= 1'b0;
            data_out_q <= '0;
        end else begin
            or_q       <= or_d;
            ddr_q      <= ddr_d;
            irl_q      <= irl_d;
            ctl_q      <= ctl_d;
            acr_q      <= acr_d;
            pcr_q      <= pcr_d;
            ifr_q      <= ifr_d;
            ier_q      <= ier_d;
            t1c_q      <= t1c_d;
            t1l_q      <= t1l_d;
            armed_q    <= armed_d;
            data_out_q <= data_out_d;
        end
    end

endmodule

// File: doc/versatile_interface_adapter.md
Name: versatile_interface_adapter

Overview:
Parametrised successor to the 6502 system's parallel I/O adapter. Provides NUM_PORTS 8-bit bidirectional ports with per-bit direction, optional edge-triggered input latching, per-port control-line interrupts, and a 16-bit interval timer with one-shot and continuous modes. Sits on the CPU data bus behind address decode and drives an active-low IRQ to the CPU.

Parameters:
NUM_PORTS, 2, number of 8-bit ports; legal range 1..4.
TIMER_WIDTH, 16, interval timer width; fixed at 16, parametrised only for the bench.

Ports:
clk  in  1  system clock; all state changes on rising edge.
reset  in  1  synchronous reset, active-low (0 = reset).
data_in  in  8  CPU write data.
data_out  out  8  CPU read data, registered.
register_select  in  4  register address.
chip_en  in  1  access strobe; access performed on edges where chip_en=1.
readb_write  in  1  1 = read, 0 = write.
port_in  in  8*NUM_PORTS  pin inputs, port p at [8p+7:8p].
port_out  out  8*NUM_PORTS  output register values.
port_oe  out  8*NUM_PORTS  per-bit output enable (the DDR value).
ctl_in  in  NUM_PORTS  per-port control/strobe line.
irq_n  out  1  active-low interrupt, equal to ~IFR[7].

Behaviour:
- Reset (reset=0 at edge): all registers, counter, armed flag, data_out, port_out, port_oe = 0; ctl_q = 0; irq_n = 1. Reset overrides any access in the same cycle.
- Register map (p = 0..3; p >= NUM_PORTS: writes ignored, reads return 0x00):
  - 0x0+p: OR p / IR p.
  - 0x4+p: DDR p.
  - 0x8: T1CL.
  - 0x9: T1CH.
  - 0xA: T1LL.
  - 0xB: T1LH.
  - 0xC: ACR. bit0 = T1 continuous; bit(1+p) = input-latch enable for port p.
  - 0xD: PCR. bit p = active edge for ctl_in[p] (1 rising, 0 falling).
  - 0xE: IFR.
  - 0xF: IER.
- Access timing:
  - Write: register updated at the access edge.
  - Read: data_out loaded at the access edge, valid the following cycle.
  - data_out holds its value when no read is in progress.
- IR read value, per bit: DDR=1 returns OR bit. DDR=0 returns the latched bit if latch is enabled, else port_in sampled at the access edge.
- Control lines:
  - ctl_q registers ctl_in every cycle. Active edge = (ctl_in & ~ctl_q) if PCR[p] is 1, or (~ctl_in & ctl_q) if PCR[p] is 0.
  - On an active edge: IFR[p] is set. If latching is enabled, IRL p captures port_in p on the same edge.
- IFR:
  - bit p = port p control flag; bit6 = T1 flag; bit7 = |(IFR[6:0] & IER[6:0]), read-only.
  - Writing a 1 to a bit clears it.
  - Reading IR p clears IFR[p]. Reading T1CL clears IFR[6].
  - If a set and a clear of the same flag occur in the same cycle, set wins.
- IER:
  - Write with data bit7=1 sets the bits given by data[6:0]. Write with data bit7=0 clears them.
  - Read returns {1, IER[6:0]}.
  - Unimplemented bits read 0.
- Timer 1:
  - Write T1CL or T1LL: updates the latch low byte.
  - Write T1LH: updates the latch high byte only.
  - Write T1CH: latch high byte = data. Counter = {data, latch_lo}. armed = 1. IFR[6] is cleared at that edge.
  - Every other edge, when counter != 0: counter decrements by 1.
  - When counter == 0: if armed, IFR[6] is set. In continuous mode, counter reloads from the latch and armed stays 1. In one-shot mode, counter becomes 0xFFFF, armed becomes 0, and the counter keeps decrementing with no further flags.
  - Result: latch value N gives the flag N+1 edges after the load edge.
  - Reads of T1CL/T1CH return the live counter; T1LL/T1LH return the latch.
- Port outputs: port_out = OR, port_oe = DDR, both registered. Changing DDR does not alter OR.

Test Plan:
- Reset, then write DDR0=0x0F and OR0=0xA5 with port_in0=0x3C, then read IR0 -> port_out0=0xA5, port_oe0=0x0F, data_out=0x35 one cycle after the read edge.
- ACR=0x02, PCR bit0=1. Raise ctl_in[0] while port_in0=0x77, then set port_in0=0x00 and read IR0 -> data_out=0x77. IFR[0] is set after the edge and cleared by the read.
- IER write 0x81, then ctl_in[0] active edge -> irq_n=0 and IFR reads 0x81. Write IFR=0x01 -> irq_n=1 the next cycle.
- One-shot: write T1LL=0x03, then T1CH=0x00 -> IFR[6] set exactly 4 edges after the T1CH edge. Counter reads 0xFFFF-based values afterwards with no second flag over 20 cycles.
- Continuous: ACR=0x01, latch=0x0002 -> IFR[6] re-set every 3 cycles. A T1CL read coinciding with a set edge leaves the flag set.
- With NUM_PORTS=1, write 0x5 (DDR1) and read 0x1 -> no state change, data_out=0x00. Assert reset mid-count -> all outputs at reset values, irq_n=1.
